ins_cache_controller: RTL and testbench

//  Direct-mapped instruction cache plus refill controller between the CPU PC/instruction fetch and
//  the 16-byte-block instruction memory. Hits return a 32-bit instruction with no stall; misses

---
 rtl/ins_cache_controller.sv | 131 +++++++++++++
 tb/tb_ins_cache_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_cache_controller.sv
// ----------------------------------------------------------------------------
// ins_cache_controller
//   Direct-mapped instruction cache with its refill controller. It sits between
//   the CPU fetch stage and an instruction memory that returns one 16-byte
//   block per read, and it is the only master of that memory's read port.
//   A hit returns the instruction with no stall. A miss raises busywait,
//   fetches the whole block, installs it in the line, and then serves the
//   fetch from the cache.
//
//   Ports
//     clock         : system clock; all state updates on the rising edge
//     reset         : asynchronous, active-low reset
//     address       : CPU byte address (PC); bits [1:0] are ignored
//     readinst      : 32-bit instruction word returned to the CPU
//     busywait      : 1 = CPU must stall and hold address stable
//     mem_read      : read request to the instruction memory
//     mem_address   : block address sent to memory (address[9:4])
//     mem_readdata  : 128-bit block; byte k occupies bits [8k+7:8k]
//     mem_busywait  : memory busy; falls once mem_readdata is valid
// ----------------------------------------------------------------------------
module ins_cache_controller #(
    parameter int INDEX_W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [9:0]   address,
    output logic [31:0]  readinst,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    localparam int TAG_W = 6 - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // Address split
    // ------------------------------------------------------------------------
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [1:0]         word;

    assign tag   = address[9 -: TAG_W];
    assign index = address[4 +: INDEX_W];
    assign word  = address[3:2];

    // Byte offset bits are not needed; fetches are always word aligned.
    logic unused_byte_offset;
    assign unused_byte_offset = ^address[1:0];

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    state_e           state_q;
    logic             mem_read_q;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     data_q [LINES];

    // ------------------------------------------------------------------------
    // Lookup: hit detection and word selection straight from the stored line
    // ------------------------------------------------------------------------
    logic hit;

    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign readinst = data_q[index][{word, 5'b0} +: 32];

    // Stall whenever a refill is in progress or the current fetch misses.
    // Held low during reset so no lookup is serviced while the cache is being
    // invalidated.
    assign busywait    = reset && ((state_q != IDLE) || !hit);
    assign mem_read    = mem_read_q;
    assign mem_address = address[9:4];

    // ------------------------------------------------------------------------
    // Refill FSM. mem_read is a registered output: it rises with entry into
    // MEM_READ and drops on the same edge that sees mem_busywait low, so the
    // memory always samples it high on that final edge.
    // ------------------------------------------------------------------------
    // NOTE: every register in a clocked block is assigned with <=, so all of
    // them update together from values sampled before the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        state_q    <= MEM_READ;
                        mem_read_q <= 1'b1;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        state_q    <= UPDATE;
                        mem_read_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    valid_q[index] <= 1'b1;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    mem_read_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: tag and data arrays are deliberately left without reset; the valid
    // bits alone decide whether a line's contents mean anything, and leaving
    // the wide arrays unreset lets them map onto plain RAM.
    always_ff @(posedge clock) begin
        if (reset && state_q == UPDATE) begin
            data_q[index] <= mem_readdata;
            tag_q[index]  <= tag;
        end
    end

endmodule

// File: tb/tb_ins_cache_controller.sv
// ----------------------------------------------------------------------------
// tb_ins_cache_controller
//   Self-checking bench for ins_cache_controller. A behavioural instruction
//   memory with programmable latency answers refills from a word image. A
//   small model of which block each line holds predicts hit or miss. Expected
//   instructions come straight from the memory image.
// ----------------------------------------------------------------------------
module tb_ins_cache_controller;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [9:0]   address = '0;
    logic [31:0]  readinst;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait;

    int errors = 0;
    int checks = 0;

    ins_cache_controller #(.INDEX_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .readinst     (readinst),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Instruction memory: 256 words, read one 4-word block at a time.
    // mem_busywait follows mem_read at once and clears after mem_lat edges.
    // ------------------------------------------------------------------------
    logic [31:0] mem_img [256];
    int   mem_lat  = 2;
    int   mem_cnt  = 0;
    int   refills  = 0;
    logic mem_done = 1'b0;

    function automatic logic [127:0] block_of(input logic [5:0] b);
        return {mem_img[{b, 2'd3}], mem_img[{b, 2'd2}],
                mem_img[{b, 2'd1}], mem_img[{b, 2'd0}]};
    endfunction

    always @(posedge clock) begin
        if (!mem_read) begin
            mem_done <= 1'b0;
            mem_cnt  <= 0;
        end else if (!mem_done) begin
            if (mem_cnt >= mem_lat - 1) begin
                mem_done     <= 1'b1;
                mem_readdata <= block_of(mem_address);
                refills      <= refills + 1;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    assign mem_busywait = mem_read & ~mem_done;

    // ------------------------------------------------------------------------
    // Reference model: which 64-block number each of the 8 lines holds.
    // ------------------------------------------------------------------------
    bit       m_valid [8];
    int       m_block [8];

    function automatic bit model_miss(input logic [9:0] a);
        int blk = int'(a[9:4]);
        return !(m_valid[blk % 8] && m_block[blk % 8] == blk);
    endfunction

    function automatic void model_fill(input logic [9:0] a);
        int blk = int'(a[9:4]);
        m_valid[blk % 8] = 1'b1;
        m_block[blk % 8] = blk;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endfunction

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One CPU fetch: present the address on a falling edge, check the stall
    // prediction, wait for busywait to drop (bounded), then check the word.
    // rel_reset releases reset in the same instant the address appears.
    task automatic fetch(input logic [9:0] a, input bit exp_miss, input string name,
                         input bit rel_reset);
        int n       = 0;
        int rd_cyc  = 0;
        bit stable  = 1'b1;
        @(negedge clock);
        address = a;
        if (rel_reset) reset = 1'b1;
        #1;
        check({name, " busywait"}, {31'b0, busywait}, {31'b0, exp_miss});
        while (busywait === 1'b1 && n < 400) begin
            @(negedge clock);
            #1;
            n++;
            if (mem_read === 1'b1) begin
                rd_cyc++;
                if (mem_address !== a[9:4]) stable = 1'b0;
            end
        end
        check({name, " stall end"}, {31'b0, busywait}, 32'd0);
        if (exp_miss) begin
            // IDLE miss cycle + (latency + 1) MEM_READ cycles + UPDATE cycle
            check({name, " penalty"}, 32'(n), 32'(mem_lat + 3));
            check({name, " mem_read cycles"}, 32'(rd_cyc), 32'(mem_lat + 1));
            check({name, " mem_address stable"}, {31'b0, stable}, 32'd1);
            model_fill(a);
        end
        check({name, " readinst"}, readinst, mem_img[a[9:2]]);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        repeat (cycles) @(negedge clock);
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors for the basic hit/miss/conflict sequence
    // ------------------------------------------------------------------------
    typedef struct {
        logic [9:0] addr;
        bit         miss;
        string      name;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_refills;
        logic [9:0] a;
        logic [9:0] prev = '0;

        for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
        mem_img[0]  = 32'h0500_00FA;
        mem_img[14] = 32'h0E04_0002;
        model_clear();

        vecs[0] = '{10'h000, 1'b1, "v0 cold miss blk0"};
        vecs[1] = '{10'h004, 1'b0, "v1 word1 hit"};
        vecs[2] = '{10'h008, 1'b0, "v2 word2 hit"};
        vecs[3] = '{10'h00C, 1'b0, "v3 word3 hit"};
        vecs[4] = '{10'h080, 1'b1, "v4 conflict tag1"};
        vecs[5] = '{10'h084, 1'b0, "v5 word1 tag1 hit"};
        vecs[6] = '{10'h000, 1'b1, "v6 refetch tag0"};
        vecs[7] = '{10'h00C, 1'b0, "v7 word3 tag0 hit"};

        // Outputs idle while reset is held, even though every line is invalid.
        repeat (3) @(negedge clock);
        #1;
        check("reset busywait", {31'b0, busywait}, 32'd0);
        check("reset mem_read", {31'b0, mem_read}, 32'd0);

        // Reset release with address 0, then words 1..3 and conflicts.
        mem_lat = 2;
        fetch(vecs[0].addr, vecs[0].miss, vecs[0].name, 1'b1);
        check("word@0x000 image", readinst, 32'h0500_00FA);
        for (int i = 1; i < 8; i++) fetch(vecs[i].addr, vecs[i].miss, vecs[i].name, 1'b0);

        // Reset pulse in the middle of a refill abandons it.
        mem_lat = 10;
        @(negedge clock);
        address = 10'h010;
        repeat (3) @(negedge clock);
        #1;
        check("mid-refill mem_read", {31'b0, mem_read}, 32'd1);
        reset = 1'b0;
        model_clear();
        #1;
        check("reset mid-refill mem_read", {31'b0, mem_read}, 32'd0);
        check("reset mid-refill busywait", {31'b0, busywait}, 32'd0);
        @(negedge clock);
        #1;
        check("reset held busywait", {31'b0, busywait}, 32'd0);
        mem_lat = 3;
        fetch(10'h000, 1'b1, "post-reset blk0 miss", 1'b1);
        fetch(10'h010, 1'b1, "post-reset blk1 miss", 1'b0);

        // Sequential PC sweep over blocks 0..3 after a fresh reset.
        apply_reset(2);
        base_refills = refills;
        fetch(10'h000, 1'b1, "sweep 0x000", 1'b1);
        for (int pc = 4; pc <= 'h3C; pc += 4) begin
            a = 10'(pc);
            fetch(a, model_miss(a), $sformatf("sweep 0x%03h", pc), 1'b0);
        end
        check("sweep refill count", 32'(refills - base_refills), 32'd4);
        check("sweep 0x038 word", mem_img[14], 32'h0E04_0002);
        fetch(10'h038, 1'b0, "recheck 0x038", 1'b0);
        check("word@0x038 direct", readinst, 32'h0E04_0002);

        // Long memory latency: mem_read and mem_address must hold throughout.
        mem_lat = 80;
        fetch(10'h200, model_miss(10'h200), "long latency", 1'b0);

        // Randomized fetch stream with random memory latency.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 1) == 0)
                a = {prev[9:4], 2'($urandom_range(0, 3)), 2'b00};
            else
                a = {6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 2'b00};
            mem_lat = $urandom_range(1, 6);
            fetch(a, model_miss(a), $sformatf("rand%0d 0x%03h", k, a), 1'b0);
            prev = a;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
